// File: rtl/store_m_if.sv
// Store-side bus bundle: start command, tile stream and byte write port.
interface store_m_if #(
    parameter int TILE_WIDTH = 256
);
    logic                  valid_in;
    logic [23:0]           dram_addr;
    logic [19:0]           length;
    logic [TILE_WIDTH-1:0] tile_in;
    logic                  tile_valid;
    logic                  tile_ready;
    logic                  mem_we;
    logic [23:0]           mem_addr;
    logic [7:0]            mem_din;
    logic                  busy;
    logic                  valid_out;

    modport master (
        output valid_in, dram_addr, length,
        output tile_in, tile_valid,
        input  tile_ready, mem_we, mem_addr,
        input  mem_din, busy, valid_out
    );

    modport slave (
        input  valid_in, dram_addr, length,
        input  tile_in, tile_valid,
        output tile_ready, mem_we, mem_addr,
        output mem_din, busy, valid_out
    );
endinterface

// File: rtl/store_m.sv
// Tile-to-DRAM byte writer, MSB byte of each tile first.
// Optional STORE_M_ZERO_PAD_EN zero-fills the tail of the final tile.
module store_m #(
    parameter int TILE_WIDTH = 256
) (
    input logic      clk,
    input logic      rst,
    store_m_if.slave bus
);
    localparam int NUM_BYTES = TILE_WIDTH / 8;
    localparam int CW = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_TILE, WRITING, NEXT_TILE, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           base_q, base_d;
    logic [23:0]           total_q, total_d;
    logic [23:0]           done_q, done_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TILE_WIDTH-1:0] tile_q, tile_d;
    logic                  tile_ready_q, tile_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [23:0]           mem_addr_q, mem_addr_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic                  busy_q, busy_d;
    logic                  valid_out_q, valid_out_d;
    logic                  last;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        total_d     = total_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        tile_d      = tile_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        valid_out_d = valid_out_q;
        last        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    base_d      = bus.dram_addr;
                    total_d     = 24'((21'(bus.length) + 21'd7) >> 3);
                    done_d      = '0;
                    valid_out_d = 1'b0;
                    state_d     = (bus.length == '0) ? DONE : WAIT_TILE;
                end
            end
            WAIT_TILE: begin
                if (bus.tile_valid && tile_ready_q) begin
                    tile_d  = bus.tile_in;
                    cnt_d   = '0;
                    state_d = WRITING;
                end
            end
            WRITING: begin
                mem_we_d   = 1'b1;
                mem_addr_d = base_q + done_q;
`ifdef STORE_M_ZERO_PAD_EN
                // Past the last length byte the rest of the tile is zeroed.
                last      = (cnt_q == CW'(NUM_BYTES - 1));
                mem_din_d = (done_q < total_q) ?
                            tile_q[TILE_WIDTH-1 -: 8] : 8'h00;
`else
                last      = (cnt_q == CW'(NUM_BYTES - 1)) ||
                            (done_q == total_q - 24'd1);
                mem_din_d = tile_q[TILE_WIDTH-1 -: 8];
`endif
                tile_d = tile_q << 8;
                cnt_d  = cnt_q + CW'(1);
                done_d = done_q + 24'd1;
                if (last) state_d = NEXT_TILE;
            end
            NEXT_TILE: begin
                state_d = (done_q < total_q) ? WAIT_TILE : DONE;
            end
            DONE: begin
                valid_out_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Ready/busy follow the state being entered so they line up with it.
        tile_ready_d = (state_d == WAIT_TILE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            total_q      <= '0;
            done_q       <= '0;
            cnt_q        <= '0;
            tile_q       <= '0;
            tile_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            busy_q       <= 1'b0;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            total_q      <= total_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            tile_q       <= tile_d;
            tile_ready_q <= tile_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            busy_q       <= busy_d;
            valid_out_q  <= valid_out_d;
        end
    end

    assign bus.tile_ready = tile_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.busy       = busy_q;
    assign bus.valid_out  = valid_out_q;
endmodule

// File: tb/tb_store_m.sv
// Directed vector bench for store_m with a 32-bit tile.
module tb_store_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_m_if #(.TILE_WIDTH(32)) bus ();
    store_m #(.TILE_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [23:0] addr;
        logic [19:0] len;
        logic [1:0]  ntiles;
        logic [63:0] tiles;
        logic [3:0]  gap;
        logic [3:0]  n_exp;
        logic [63:0] exp_data;
    } vec_t;

    vec_t v [6];
    int   passed = 0;
    int   total = 0;

    logic [23:0] log_a [$];
    logic [7:0]  log_d [$];
    int          tr_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (bus.mem_we) begin
            log_a.push_back(bus.mem_addr);
            log_d.push_back(bus.mem_din);
        end
        if (bus.tile_ready) tr_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic start(input vec_t t);
        bus.valid_in  = 1'b1;
        bus.dram_addr = t.addr;
        bus.length    = t.len;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t t;
        int   lat, stall_we, w;
        logic [23:0] ea;
        t = v[k];
        log_a.delete();
        log_d.delete();
        tr_cnt = 0;
        stall_we = 0;
        start(t);
        chk($sformatf("v%0d_vo_clr", k), 32'(bus.valid_out), 0);
        chk($sformatf("v%0d_busy", k), 32'(bus.busy), 1);
        lat = 1;
        for (int n = 0; n < int'(t.ntiles); n++) begin
            w = 0;
            while (!bus.tile_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!bus.tile_ready) begin
                chk($sformatf("v%0d_tile_ready_to", k), 0, 1);
                break;
            end
            if (n > 0) begin
                for (int g = 0; g < int'(t.gap); g++) begin
                    @(negedge clk);
                    if (bus.mem_we) stall_we++;
                end
            end
            bus.tile_valid = 1'b1;
            bus.tile_in = (n == 0) ? t.tiles[63:32] : t.tiles[31:0];
            @(negedge clk);
            bus.tile_valid = 1'b0;
        end
        w = 0;
        while (!bus.valid_out && w < 60) begin
            @(negedge clk);
            w++;
            lat++;
        end
        chk($sformatf("v%0d_valid_out", k), 32'(bus.valid_out), 1);
        if (t.len == 0) begin
            chk("len0_latency", 32'(lat <= 2), 1);
            chk("len0_no_ready", tr_cnt, 0);
        end
        if (t.gap != 0) chk("stall_we", stall_we, 0);
        chk($sformatf("v%0d_nwr_at_done", k), log_a.size(), 32'(t.n_exp));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_nwr", k), log_a.size(), 32'(t.n_exp));
        chk($sformatf("v%0d_idle", k), 32'(bus.busy), 0);
        for (int i = 0; i < int'(t.n_exp) && i < log_a.size(); i++) begin
            ea = t.addr + 24'(i);
            chk($sformatf("v%0d_a%0d", k, i), 32'(log_a[i]), 32'(ea));
            chk($sformatf("v%0d_d%0d", k, i), 32'(log_d[i]),
                32'(t.exp_data[63-8*i -: 8]));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_din"}, 32'(bus.mem_din), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_vo"}, 32'(bus.valid_out), 0);
        chk({tag, "_rdy"}, 32'(bus.tile_ready), 0);
    endtask

    initial begin
        int w;
        v[0] = '{24'h000100, 20'd64, 2'd2, 64'hA1B2C3D4_11223344,
                 4'd0, 4'd8, 64'hA1B2C3D4_11223344};
        v[1] = '{24'h000100, 20'd64, 2'd2, 64'hA1B2C3D4_11223344,
                 4'd5, 4'd8, 64'hA1B2C3D4_11223344};
`ifdef STORE_M_ZERO_PAD_EN
        v[2] = '{24'h000100, 20'd20, 2'd1, 64'hDEADBEEF_00000000,
                 4'd0, 4'd4, 64'hDEADBE00_00000000};
        v[5] = '{24'h000200, 20'd40, 2'd2, 64'h01020304_05060708,
                 4'd0, 4'd8, 64'h01020304_05000000};
`else
        v[2] = '{24'h000100, 20'd20, 2'd1, 64'hDEADBEEF_00000000,
                 4'd0, 4'd3, 64'hDEADBE00_00000000};
        v[5] = '{24'h000200, 20'd40, 2'd2, 64'h01020304_05060708,
                 4'd0, 4'd5, 64'h01020304_05000000};
`endif
        v[3] = '{24'h000100, 20'd0, 2'd0, 64'h0,
                 4'd0, 4'd0, 64'h0};
        v[4] = '{24'hFFFFFE, 20'd32, 2'd1, 64'hCAFEBABE_00000000,
                 4'd0, 4'd4, 64'hCAFEBABE_00000000};

        bus.valid_in   = 1'b0;
        bus.dram_addr  = '0;
        bus.length     = '0;
        bus.tile_in    = '0;
        bus.tile_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Reset in the middle of a transfer after two bytes.
        log_a.delete();
        log_d.delete();
        start(v[0]);
        bus.tile_valid = 1'b1;
        bus.tile_in    = 32'hA1B2C3D4;
        @(negedge clk);
        bus.tile_valid = 1'b0;
        w = 0;
        while (log_a.size() < 2 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mid_two_wr", log_a.size(), 2);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_nwr", log_a.size(), 2);
        run_vec(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/store_m.md
STORE_M -- requirements
Module: store_m

Interface
REQ-001 Parameter TILE_WIDTH, default 256, tile width in bits; SHALL be a multiple of 8; NUM_BYTES = TILE_WIDTH/8.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 valid_in  input  1  start strobe; sampled only in IDLE.
REQ-005 dram_addr  input  24  first byte address; captured on accepted start.
REQ-006 length  input  20  transfer length in bits; captured on accepted start.
REQ-007 tile_in  input  TILE_WIDTH  tile data; MSB byte is written first.
REQ-008 tile_valid  input  1  tile_in is valid.
REQ-009 tile_ready  output  1  block accepts a tile this cycle.
REQ-010 mem_we  output  1  byte write enable to memory.
REQ-011 mem_addr  output  24  byte write address.
REQ-012 mem_din  output  8  byte write data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 valid_out  output  1  transfer-complete flag.

Function
REQ-015 States SHALL be IDLE, WAIT_TILE, WRITING, NEXT_TILE and DONE; all outputs SHALL be registered.
REQ-016 IDLE: on valid_in=1, the block SHALL latch dram_addr and length, set total_bytes = ceil(length/8) and bytes_done = 0, clear valid_out, and go to WAIT_TILE; if length = 0 it SHALL go to DONE instead.
REQ-017 WAIT_TILE: tile_ready = 1; on tile_valid && tile_ready the block SHALL latch tile_in, set byte_cnt = 0 and go to WRITING; tile_ready SHALL be 0 in all other states.
REQ-018 WRITING: each cycle the block SHALL drive mem_we = 1, mem_addr = base + bytes_done, and mem_din = tile[(NUM_BYTES-1-byte_cnt)*8 +: 8], then increment byte_cnt and bytes_done.
REQ-019 WRITING SHALL exit to NEXT_TILE after byte NUM_BYTES-1, or after the byte with bytes_done = total_bytes-1, whichever comes first.
REQ-020 NEXT_TILE: mem_we = 0; the block SHALL go to WAIT_TILE if bytes_done < total_bytes, else to DONE.
REQ-021 DONE: the block SHALL set valid_out = 1 and go to IDLE; valid_out SHALL stay 1 until the next accepted valid_in.
REQ-022 A partial final byte (length not a multiple of 8) SHALL be written in full from the tile byte.
REQ-023 valid_in SHALL be ignored outside IDLE; no abort.
REQ-024 mem_addr arithmetic SHALL be 24-bit and wrap modulo 2^24.
REQ-025 Throughput: one byte per cycle in WRITING; a stalled tile_valid SHALL hold the block in WAIT_TILE with mem_we = 0.
REQ-026 Tile order: the first tile accepted SHALL map to addresses base..base+NUM_BYTES-1; each later tile SHALL continue contiguously.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL go to IDLE with valid_out, busy, tile_ready, mem_we, mem_addr, mem_din, counters and tile register all 0.
REQ-028 A reset during a transfer SHALL abandon it at once; no further writes SHALL occur, and bytes already written SHALL not be undone.

Configuration
REQ-029 Macro STORE_M_ZERO_PAD_EN: when defined, after the last length byte of the final tile, WRITING SHALL keep writing 0x00 to the rest of that tile (through byte NUM_BYTES-1), mirroring the load side's zero fill.
REQ-030 When STORE_M_ZERO_PAD_EN is not defined, no bytes beyond ceil(length/8) SHALL be written.

Verification (TILE_WIDTH=32 unless stated)
REQ-031 Start at addr 0x000100, length 64, tiles 0xA1B2C3D4 then 0x11223344 -> 8 writes, addr 0x100..0x107, data A1 B2 C3 D4 11 22 33 44; valid_out rises after the last write.
REQ-032 Length 20, tile 0xDEADBEEF -> writes DE AD BE to 0x100..0x102; with STORE_M_ZERO_PAD_EN, an extra 00 to 0x103.
REQ-033 Length 0 -> no mem_we and no tile_ready; valid_out = 1 within 2 cycles.
REQ-034 tile_valid held low 5 cycles between tiles -> mem_we stays 0 during the stall; resulting memory image identical to REQ-031.
REQ-035 Start at 0xFFFFFE, length 32 -> writes to 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-036 rst asserted after 2 bytes of REQ-031 -> only 2 writes occur; all outputs 0 on the next cycle; a new start then completes normally.
